// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the I/D single-port RAM arbiter.
package ram_arbiter_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 8;

  // One-hot grant encoding: bit 0 = instruction port, bit 1 = data port.
  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_I    = 2'b01,
    GNT_D    = 2'b10
  } gnt_e;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way combinational arbiter: round-robin on contention, or fixed D priority.
module ram_arbiter_rr_arb2
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] req_i,        // bit 0 = I, bit 1 = D
  input  logic       last_d_i,     // 1 = D held the most recent grant
  input  logic       prio_mode_i,  // 1 = D always wins contention
  output gnt_e       gnt_o_c
);

  always_comb begin
    gnt_o_c = GNT_NONE;
    case (req_i)
      2'b01:   gnt_o_c = GNT_I;
      2'b10:   gnt_o_c = GNT_D;
      2'b11:   gnt_o_c = (prio_mode_i || !last_d_i) ? GNT_D : GNT_I;
      default: gnt_o_c = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port, byte-writable, 1-cycle-latency RAM between the CPU
// instruction-fetch (I) and load/store (D) ports, one access per cycle.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH         = 16384,
  parameter int unsigned ADDRESS_WIDTH = $clog2(DEPTH),
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned D_PRIORITY    = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_req,
  input  logic [ADDRESS_WIDTH-3:0] i_addr,
  output logic                     i_ack,
  output logic [DATA_WIDTH-1:0]    i_rdata,
  input  logic                     d_req,
  input  logic [LANES-1:0]         d_we,
  input  logic [ADDRESS_WIDTH-3:0] d_addr,
  input  logic [DATA_WIDTH-1:0]    d_wdata,
  output logic                     d_ack,
  output logic [DATA_WIDTH-1:0]    d_rdata,
  output logic [LANES-1:0]         ram_we,
  output logic [ADDRESS_WIDTH-3:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_data,
  input  logic [DATA_WIDTH-1:0]    ram_q
);

  localparam logic PRIO_MODE = (D_PRIORITY != 0);

  logic       pend_i_q, pend_i_d;
  logic       pend_d_q, pend_d_d;
  logic       last_d_q, last_d_d;
  logic [1:0] elig_c;
  gnt_e       gnt_c;
  logic       gnt_i_c, gnt_d_c;

  // A port granted last cycle is masked while its ack is out, so a request the
  // requester has not yet dropped is not serviced twice. Nothing is granted in reset.
  always_comb begin
    elig_c[0] = i_req & ~pend_i_q & rst_n;
    elig_c[1] = d_req & ~pend_d_q & rst_n;
  end

  ram_arbiter_rr_arb2 u_rr_arb2 (
    .req_i       (elig_c),
    .last_d_i    (last_d_q),
    .prio_mode_i (PRIO_MODE),
    .gnt_o_c     (gnt_c)
  );

  // RAM is driven straight from the grant so it samples the access this cycle.
  always_comb begin
    gnt_i_c  = (gnt_c == GNT_I);
    gnt_d_c  = (gnt_c == GNT_D);
    ram_we   = gnt_d_c ? d_we : '0;
    ram_addr = gnt_i_c ? i_addr : d_addr;
    ram_data = d_wdata;
    pend_i_d = gnt_i_c;
    pend_d_d = gnt_d_c;
    last_d_d = last_d_q;
    if (gnt_d_c) last_d_d = 1'b1;
    else if (gnt_i_c) last_d_d = 1'b0;
  end

  // Reset clears any in-flight ack; last starts at D so I wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_i_q <= 1'b0;
      pend_d_q <= 1'b0;
      last_d_q <= 1'b1;
    end else begin
      pend_i_q <= pend_i_d;
      pend_d_q <= pend_d_d;
      last_d_q <= last_d_d;
    end
  end

  assign i_ack   = pend_i_q;
  assign d_ack   = pend_d_q;
  assign i_rdata = ram_q;
  assign d_rdata = ram_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: shadow-memory model, decoupled ack monitor,
// directed protocol scenarios plus a randomized concurrent I/D phase.
module tb_ram_arbiter;

  localparam int unsigned AW    = 12;
  localparam int unsigned WORDS = 4096;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req, d_req, i_ack, d_ack;
  logic [AW-1:0] i_addr, d_addr, ram_addr;
  logic [3:0]    d_we, ram_we;
  logic [31:0]   d_wdata, i_rdata, d_rdata, ram_data, ram_q;

  logic          p_i_req, p_d_req, p_i_ack, p_d_ack;
  logic [AW-1:0] p_i_addr, p_d_addr, p_ram_addr;
  logic [3:0]    p_d_we, p_ram_we;
  logic [31:0]   p_d_wdata, p_i_rdata, p_d_rdata, p_ram_data, p_ram_q;

  logic          fill;
  logic [31:0]   mem    [WORDS];
  logic [31:0]   shadow [WORDS];
  logic [31:0]   exp_i[$];
  logic [31:0]   exp_d[$];
  int            total = 0;
  int            bad   = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.DEPTH(16384), .ADDRESS_WIDTH(14), .DATA_WIDTH(32), .D_PRIORITY(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .ram_q(ram_q)
  );

  ram_arbiter #(.DEPTH(16384), .ADDRESS_WIDTH(14), .DATA_WIDTH(32), .D_PRIORITY(1)) dut_p (
    .clk(clk), .rst_n(rst_n),
    .i_req(p_i_req), .i_addr(p_i_addr), .i_ack(p_i_ack), .i_rdata(p_i_rdata),
    .d_req(p_d_req), .d_we(p_d_we), .d_addr(p_d_addr), .d_wdata(p_d_wdata),
    .d_ack(p_d_ack), .d_rdata(p_d_rdata),
    .ram_we(p_ram_we), .ram_addr(p_ram_addr), .ram_data(p_ram_data), .ram_q(p_ram_q)
  );

  function automatic logic [31:0] init_word(input int unsigned k);
    return 32'hC0DE0000 ^ (32'(k) * 32'h00010003);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  // Single-port byte-writable RAM, registered read returning the old word.
  always @(posedge clk) begin
    if (fill) begin
      for (int k = 0; k < WORDS; k++) mem[k] <= init_word(k);
    end else begin
      ram_q <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_data[8*b +: 8];
    end
  end

  // Priority instance reads back its own word address (write data is held at zero).
  always @(posedge clk) p_ram_q <= 32'(p_ram_addr) | p_ram_data;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every ack pops the matching scoreboard entry.
  initial forever begin
    @(negedge clk);
    if (i_ack || d_ack) check("dual_ack", 32'(i_ack & d_ack), 32'h0);
    if (i_ack) begin
      if (exp_i.size() == 0) check("i_ack_unexpected", 32'(i_ack), 32'h0);
      else check("i_rdata", i_rdata, exp_i.pop_front());
    end
    if (d_ack) begin
      if (exp_d.size() == 0) check("d_ack_unexpected", 32'(d_ack), 32'h0);
      else check("d_rdata", d_rdata, exp_d.pop_front());
    end
    if (p_i_ack) check("p_i_rdata", p_i_rdata, 32'(p_i_addr));
    if (p_d_ack) check("p_d_rdata", p_d_rdata, 32'(p_d_addr));
  end

  // Both access tasks start and return just after a rising edge.
  task automatic d_access(input logic [3:0] we, input logic [AW-1:0] addr,
                          input logic [31:0] data, output int lat, output logic [31:0] rd);
    logic seen;
    exp_d.push_back(shadow[addr]);
    shadow[addr] = merge(shadow[addr], data, we);
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = data;
    seen = 1'b0; lat = 0; rd = '0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(posedge clk); @(negedge clk);
      if (d_ack) begin seen = 1'b1; lat = n; rd = d_rdata; end
    end
    check("d_ack_seen", 32'(seen), 32'h1);
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 4'h0;
  endtask

  task automatic i_access(input logic [AW-1:0] addr, output int lat);
    logic seen;
    exp_i.push_back(shadow[addr]);
    i_req = 1'b1; i_addr = addr;
    seen = 1'b0; lat = 0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(posedge clk); @(negedge clk);
      if (i_ack) begin seen = 1'b1; lat = n; end
    end
    check("i_ack_seen", 32'(seen), 32'h1);
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic [1:0]  prev, cur;

    rst_n = 1'b0; fill = 1'b1;
    i_req = 0; d_req = 0; i_addr = '0; d_addr = '0; d_we = '0; d_wdata = '0;
    p_i_req = 0; p_d_req = 0; p_i_addr = 12'd7; p_d_addr = 12'd9; p_d_we = '0; p_d_wdata = '0;
    for (int k = 0; k < WORDS; k++) shadow[k] = init_word(k);
    @(posedge clk); #1 fill = 1'b0;

    // Requests held through reset: nothing granted, nothing acked.
    i_req = 1; i_addr = 12'h010;
    d_req = 1; d_we = 4'hF; d_addr = 12'h030; d_wdata = 32'h12345678;
    exp_i.push_back(shadow[12'h010]);
    exp_d.push_back(shadow[12'h030]);
    shadow[12'h030] = merge(shadow[12'h030], 32'h12345678, 4'hF);
    repeat (3) begin
      @(negedge clk);
      check("rst_ram_we", 32'(ram_we), 32'h0);
      check("rst_i_ack", 32'(i_ack), 32'h0);
      check("rst_d_ack", 32'(d_ack), 32'h0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("first_grant_addr", 32'(ram_addr), 32'h010);
    check("first_grant_we", 32'(ram_we), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("first_i_ack", 32'(i_ack), 32'h1);
    check("second_grant_we", 32'(ram_we), 32'hF);
    @(posedge clk); #1 i_req = 0;
    @(negedge clk);
    check("first_d_ack", 32'(d_ack), 32'h1);
    @(posedge clk); #1 d_req = 0; d_we = 0;

    // Full-word write then read-back.
    d_access(4'hF, 12'h020, 32'hDEADBEEF, lat, rd);
    check("d_write_latency", 32'(lat), 32'h1);
    d_access(4'h0, 12'h020, 32'h0, lat, rd);
    check("d_read_back", rd, 32'hDEADBEEF);

    // Single byte lane merge.
    d_access(4'hF, 12'h024, 32'h11223344, lat, rd);
    d_access(4'b0100, 12'h024, 32'h00AA0000, lat, rd);
    d_access(4'h0, 12'h024, 32'h0, lat, rd);
    check("byte_lane", rd, 32'h11AA3344);

    // Contention: last grant was D, so I goes first, then strict alternation.
    i_addr = 12'h001; d_addr = 12'h002; d_we = 4'h0;
    repeat (4) begin exp_i.push_back(shadow[12'h001]); exp_d.push_back(shadow[12'h002]); end
    i_req = 1; d_req = 1; prev = 2'b00;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k == 7) i_req = 0;
      @(negedge clk);
      cur = {d_ack, i_ack};
      check("rr_one_ack", 32'({1'b0, i_ack} + {1'b0, d_ack}), 32'h1);
      if (k == 0) check("rr_first_i", 32'(i_ack), 32'h1);
      else check("rr_alternate", 32'(cur == prev), 32'h0);
      prev = cur;
    end
    @(posedge clk); #1 d_req = 0;

    // Lone requester holding req: one access every other cycle.
    i_addr = 12'h003;
    repeat (3) exp_i.push_back(shadow[12'h003]);
    i_req = 1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (k == 5) i_req = 0;
      @(negedge clk);
      check("single_i_ack", 32'(i_ack), (k % 2 == 0) ? 32'h1 : 32'h0);
      check("single_d_idle", 32'(d_ack), 32'h0);
    end
    @(posedge clk); #1;

    // D-priority instance: D wins contention even right after its own grant.
    p_d_req = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("p_d_only_ack", 32'(p_d_ack), 32'h1);
    @(posedge clk); #1 p_d_req = 0;
    p_i_req = 1; p_d_req = 1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (k == 5) p_d_req = 0;
      @(negedge clk);
      check("prio_d_ack", 32'(p_d_ack), (k % 2 == 0) ? 32'h1 : 32'h0);
      check("prio_i_ack", 32'(p_i_ack), (k % 2 == 1) ? 32'h1 : 32'h0);
      check("prio_ram_we", 32'(p_ram_we), 32'h0);
    end
    @(posedge clk); #1 p_i_req = 0;
    @(posedge clk); #1;

    // Reset while a D write's ack is pending: no ack, but the write is committed.
    d_req = 1; d_we = 4'hF; d_addr = 12'h050; d_wdata = 32'hCAFEF00D;
    shadow[12'h050] = 32'hCAFEF00D;
    @(negedge clk);
    check("mid_rst_d_grant", 32'(ram_we), 32'hF);
    @(posedge clk); #1 rst_n = 0; d_req = 0; d_we = 0;
    @(negedge clk);
    check("mid_rst_no_d_ack", 32'(d_ack), 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1;
    d_access(4'h0, 12'h050, 32'h0, lat, rd);
    check("mid_rst_committed", rd, 32'hCAFEF00D);

    // Reset while an I read's ack is pending.
    i_req = 1; i_addr = 12'h060;
    @(negedge clk);
    check("mid_rst_i_grant", 32'(ram_addr), 32'h060);
    @(posedge clk); #1 rst_n = 0; i_req = 0;
    @(negedge clk);
    check("mid_rst_no_i_ack", 32'(i_ack), 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1;
    repeat (2) begin @(posedge clk); #1; end

    // Randomized concurrent traffic; I reads a region D never writes.
    fork
      begin
        int ilat;
        for (int n = 0; n < 30; n++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          i_access(12'h800 + 12'($urandom_range(0, 15)), ilat);
        end
      end
      begin
        int          dlat;
        logic [31:0] drd;
        logic [3:0]  we;
        for (int n = 0; n < 30; n++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          we = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
          d_access(we, 12'h040 + 12'($urandom_range(0, 15)), $urandom, dlat, drd);
        end
      end
    join
    repeat (3) begin @(posedge clk); #1; end
    check("i_queue_drained", 32'(exp_i.size()), 32'h0);
    check("d_queue_drained", 32'(exp_d.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
